// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared encodings for the MIPS write-back stage:
//   - result source select (in_sel) and load-extension mode (in_ext)
//   - occupancy state of the two-entry skid buffer
//   - default-width view of a buffered entry (wen, rd, data)
//   - entry_wen(): decides whether an instruction really writes a register
// ---------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_LINK = 2'b10,
        SEL_NONE = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        EXT_WORD = 2'b00,   // full width, no extension
        EXT_SB   = 2'b01,   // low byte, sign-extended
        EXT_ZB   = 2'b10,   // low byte, zero-extended
        EXT_ZH   = 2'b11    // high byte of the halfword, zero-extended
    } wb_ext_e;

    // Occupancy of the buffer: ONE = head only, TWO = head + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_e;

    localparam int WB_DATA_W  = 16;
    localparam int WB_RADDR_W = 3;

    // Entry layout at default widths; the top level declares the same
    // layout with its own parameter widths.
    typedef struct packed {
        logic                  wen;
        logic [WB_RADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    // Register 0 is hard-wired, and SEL_NONE means the instruction produces
    // no register result, so both suppress the write.
    function automatic logic entry_wen(input logic we, input logic [1:0] sel,
                                       input logic rd_nonzero);
        return we && (sel != SEL_NONE) && rd_nonzero;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// ---------------------------------------------------------------------------
// wb_skid_buffer
// Generic two-entry valid/ready buffer. The head holds the older entry and
// is presented downstream; the skid holds a younger entry that arrived while
// the head was stalled. Both entries are visible for forwarding lookups.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   in_valid        upstream offers in_data
//   in_ready        buffer can accept (registered, low only when full)
//   in_data         payload, PW bits
//   head_valid      head entry present
//   head_data       head payload
//   head_ready      downstream lets the head retire this cycle
//   skid_valid      skid entry present
//   skid_data       skid payload
//   retire          head leaves the buffer at this edge
// ---------------------------------------------------------------------------
module wb_skid_buffer
    import wb_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          head_valid,
    output logic [PW-1:0] head_data,
    input  logic          head_ready,
    output logic          skid_valid,
    output logic [PW-1:0] skid_data,
    output logic          retire
);

    wb_state_e     r_state;
    wb_state_e     w_state_next;
    logic          r_in_ready;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_skid;
    logic          w_accept;
    logic          w_retire;

    assign head_valid = (r_state != EMPTY);
    assign skid_valid = (r_state == TWO);
    assign head_data  = r_head;
    assign skid_data  = r_skid;
    assign in_ready   = r_in_ready;
    assign retire     = w_retire;

    assign w_accept = in_valid && r_in_ready;
    assign w_retire = head_valid && head_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_next = ONE;
            ONE: begin
                if (w_accept && !w_retire)      w_state_next = TWO;
                else if (!w_accept && w_retire) w_state_next = EMPTY;
            end
            TWO:     if (w_retire) w_state_next = ONE;
            default: w_state_next = EMPTY;
        endcase
    end

    // in_ready is the flopped "not full" of the next state, so it never
    // depends combinationally on downstream readiness.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != TWO);
            case (r_state)
                EMPTY: if (w_accept) r_head <= in_data;
                ONE: begin
                    // With a simultaneous retire the new entry replaces the
                    // head directly instead of passing through the skid.
                    if (w_accept && w_retire) r_head <= in_data;
                    else if (w_accept)        r_skid <= in_data;
                end
                TWO:   if (w_retire) r_head <= r_skid;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// MIPS write-back stage: picks the result source, applies load extension,
// buffers up to two retiring instructions in front of the register-file
// write port, serves operand-forwarding lookups from the buffered entries,
// and keeps the last written value (ans_wb) and a retire counter.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready registered)
//   in_alu, in_mem, in_link    candidate results
//   in_sel, in_ext             source select, memory extension mode
//   in_we, in_rd               register write intent and destination
//   rf_we, rf_waddr, rf_wdata  register-file write request (from head)
//   rf_ready                   register file accepts the write this cycle
//   fwd_raddr / fwd_hit / fwd_data   per-port forwarding lookup
//   ans_wb                     last value written to the register file
//   retire_cnt, cnt_clr        retired-instruction counter and its clear
// ---------------------------------------------------------------------------
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 3,
    parameter int FWD_PORTS = 2,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_alu,
    input  logic [DATA_W-1:0]              in_mem,
    input  logic [DATA_W-1:0]              in_link,
    input  logic [1:0]                     in_sel,
    input  logic [1:0]                     in_ext,
    input  logic                           in_we,
    input  logic [RADDR_W-1:0]             in_rd,
    output logic                           rf_we,
    output logic [RADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]              rf_wdata,
    input  logic                           rf_ready,
    input  logic [FWD_PORTS*RADDR_W-1:0]   fwd_raddr,
    output logic [FWD_PORTS-1:0]           fwd_hit,
    output logic [FWD_PORTS*DATA_W-1:0]    fwd_data,
    output logic [DATA_W-1:0]              ans_wb,
    output logic [CNT_W-1:0]               retire_cnt,
    input  logic                           cnt_clr
);

    typedef struct packed {
        logic               wen;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  data;
    } entry_t;

    localparam int PW = $bits(entry_t);

    logic [DATA_W-1:0] w_mem_ext;
    logic [DATA_W-1:0] w_result;
    entry_t            w_in_entry;
    entry_t            w_head;
    entry_t            w_skid;
    logic              w_head_valid;
    logic              w_skid_valid;
    logic              w_head_ready;
    logic              w_retire;
    logic [DATA_W-1:0] r_ans_wb;
    logic [CNT_W-1:0]  r_retire_cnt;

    // Load extension; "high byte" is bits [15:8] of the loaded halfword.
    always_comb begin
        w_mem_ext = in_mem;
        case (wb_ext_e'(in_ext))
            EXT_WORD: w_mem_ext = in_mem;
            EXT_SB:   w_mem_ext = {{(DATA_W-8){in_mem[7]}}, in_mem[7:0]};
            EXT_ZB:   w_mem_ext = {{(DATA_W-8){1'b0}}, in_mem[7:0]};
            EXT_ZH:   w_mem_ext = {{(DATA_W-8){1'b0}}, in_mem[15:8]};
            default:  w_mem_ext = in_mem;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (wb_sel_e'(in_sel))
            SEL_ALU:  w_result = in_alu;
            SEL_MEM:  w_result = w_mem_ext;
            SEL_LINK: w_result = in_link;
            default:  w_result = '0;
        endcase
    end

    assign w_in_entry.wen  = entry_wen(in_we, in_sel, in_rd != '0);
    assign w_in_entry.rd   = in_rd;
    assign w_in_entry.data = w_result;

    // Non-writing entries have nothing to hand to the register file, so
    // they leave without waiting for rf_ready.
    assign w_head_ready = rf_ready || !w_head.wen;

    wb_skid_buffer #(
        .PW(PW)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (w_in_entry),
        .head_valid (w_head_valid),
        .head_data  (w_head),
        .head_ready (w_head_ready),
        .skid_valid (w_skid_valid),
        .skid_data  (w_skid),
        .retire     (w_retire)
    );

    assign rf_we    = w_head_valid && w_head.wen;
    assign rf_waddr = w_head.rd;
    assign rf_wdata = w_head.data;

    // Forwarding: the skid entry is younger, so it overrides the head.
    for (genvar gi = 0; gi < FWD_PORTS; gi++) begin : g_fwd
        logic [RADDR_W-1:0] w_raddr;
        logic               w_hit_head;
        logic               w_hit_skid;

        assign w_raddr    = fwd_raddr[gi*RADDR_W +: RADDR_W];
        assign w_hit_skid = w_skid_valid && w_skid.wen &&
                            (w_skid.rd == w_raddr) && (w_raddr != '0);
        assign w_hit_head = w_head_valid && w_head.wen &&
                            (w_head.rd == w_raddr) && (w_raddr != '0);

        assign fwd_hit[gi] = w_hit_skid || w_hit_head;
        assign fwd_data[gi*DATA_W +: DATA_W] =
            w_hit_skid ? w_skid.data : (w_hit_head ? w_head.data : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ans_wb     <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_retire && w_head.wen) r_ans_wb <= w_head.data;
            if (cnt_clr)                r_retire_cnt <= '0;
            else if (w_retire)          r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign ans_wb     = r_ans_wb;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Directed bench for writeback_stage with a queue-based reference model.
// The model holds buffered instructions in arrival order (at most two);
// outputs are compared against it on every falling edge, and a set of
// literal expectations pins the scenarios from the test plan.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_alu, in_mem, in_link;
    logic [1:0]  in_sel, in_ext;
    logic        in_we;
    logic [2:0]  in_rd;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [5:0]  fwd_raddr;
    logic [1:0]  fwd_hit;
    logic [31:0] fwd_data;
    logic [15:0] ans_wb;
    logic [15:0] retire_cnt;
    logic        cnt_clr;

    int n_pass  = 0;
    int n_total = 0;

    writeback_stage #(
        .DATA_W(16), .RADDR_W(3), .FWD_PORTS(2), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
        .in_sel(in_sel), .in_ext(in_ext), .in_we(in_we), .in_rd(in_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_ready(rf_ready),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .ans_wb(ans_wb), .retire_cnt(retire_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        wen;
        logic [2:0]  rd;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_ans;
    logic [15:0] m_cnt;

    function automatic logic [15:0] model_value(input logic [1:0] sel,
            input logic [15:0] alu, input logic [15:0] mem,
            input logic [15:0] link, input logic [1:0] ext);
        logic [15:0] v;
        v = 16'h0000;
        if (sel == 2'd0) v = alu;
        else if (sel == 2'd2) v = link;
        else if (sel == 2'd1) begin
            if (ext == 2'd0)      v = mem;
            else if (ext == 2'd1) v = {{8{mem[7]}}, mem[7:0]};
            else if (ext == 2'd2) v = {8'h00, mem[7:0]};
            else                  v = {8'h00, mem[15:8]};
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ans = 16'h0;
            m_cnt = 16'h0;
        end else begin
            logic acc, ret;
            ent_t e;
            acc = in_valid && (mq.size() < 2);
            ret = (mq.size() > 0) && (rf_ready || !mq[0].wen);
            if (cnt_clr)  m_cnt = 16'h0;
            else if (ret) m_cnt = m_cnt + 16'h1;
            if (ret) begin
                if (mq[0].wen) m_ans = mq[0].data;
                void'(mq.pop_front());
            end
            if (acc) begin
                e.wen  = in_we && (in_sel != 2'd3) && (in_rd != 3'd0);
                e.rd   = in_rd;
                e.data = model_value(in_sel, in_alu, in_mem, in_link, in_ext);
                mq.push_back(e);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic        exp_we;
        logic [1:0]  exp_hit;
        logic [31:0] exp_fd;
        exp_we = 1'b0;
        if (mq.size() > 0) exp_we = mq[0].wen;
        check("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
        check("rf_we", {31'b0, rf_we}, {31'b0, exp_we});
        if (mq.size() > 0) check("rf_waddr", {29'b0, rf_waddr}, {29'b0, mq[0].rd});
        if (exp_we) check("rf_wdata", {16'b0, rf_wdata}, {16'b0, mq[0].data});
        exp_hit = 2'b00;
        exp_fd  = 32'h0;
        for (int p = 0; p < 2; p++) begin
            logic [2:0] a;
            a = fwd_raddr[p*3 +: 3];
            // youngest matching entry wins
            for (int j = 0; j < mq.size(); j++) begin
                if (mq[j].wen && mq[j].rd == a && a != 3'd0) begin
                    exp_hit[p] = 1'b1;
                    exp_fd[p*16 +: 16] = mq[j].data;
                end
            end
        end
        check("fwd_hit", {30'b0, fwd_hit}, {30'b0, exp_hit});
        check("fwd_data", fwd_data, exp_fd);
        check("ans_wb", {16'b0, ans_wb}, {16'b0, m_ans});
        check("retire_cnt", {16'b0, retire_cnt}, {16'b0, m_cnt});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] sel, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [1:0] ext,
                         input logic we, input logic [2:0] rd);
        in_valid = 1'b1;
        in_sel   = sel;
        in_alu   = alu;
        in_mem   = mem;
        in_link  = 16'hC0DE;
        in_ext   = ext;
        in_we    = we;
        in_rd    = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        int   k;
        logic rdy;
        rst_n = 1'b0;
        in_valid = 1'b0; in_alu = '0; in_mem = '0; in_link = '0;
        in_sel = '0; in_ext = '0; in_we = 1'b0; in_rd = '0;
        rf_ready = 1'b0; fwd_raddr = '0; cnt_clr = 1'b0;
        tick(); tick();
        check("reset_rf_waddr", {29'b0, rf_waddr}, 32'h0);
        check("reset_rf_wdata", {16'b0, rf_wdata}, 32'h0);
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        rst_n = 1'b1;
        tick();

        // single ALU write
        rf_ready = 1'b1;
        offer(2'd0, 16'h1234, 16'h0, 2'd0, 1'b1, 3'd5);
        tick();
        idle();
        check("alu_rf_we", {31'b0, rf_we}, 32'h1);
        check("alu_rf_waddr", {29'b0, rf_waddr}, 32'h5);
        check("alu_rf_wdata", {16'b0, rf_wdata}, 32'h1234);
        tick();
        check("alu_ans_wb", {16'b0, ans_wb}, 32'h1234);
        check("alu_cnt", {16'b0, retire_cnt}, 32'h1);

        // load extension, back to back
        offer(2'd1, 16'h0, 16'h00F3, 2'd1, 1'b1, 3'd1);
        tick();
        check("ext_sb", {16'b0, rf_wdata}, 32'hFFF3);
        offer(2'd1, 16'h0, 16'h00F3, 2'd2, 1'b1, 3'd2);
        tick();
        check("ext_zb", {16'b0, rf_wdata}, 32'h00F3);
        offer(2'd1, 16'h0, 16'hAB00, 2'd3, 1'b1, 3'd3);
        tick();
        check("ext_zh", {16'b0, rf_wdata}, 32'h00AB);
        idle();
        tick();
        check("ext_cnt", {16'b0, retire_cnt}, 32'h4);

        // counter clear
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", {16'b0, retire_cnt}, 32'h0);

        // backpressure: three entries against a stalled port
        rf_ready = 1'b0;
        offer(2'd0, 16'h0101, 16'h0, 2'd0, 1'b1, 3'd1);
        tick();
        offer(2'd0, 16'h0202, 16'h0, 2'd0, 1'b1, 3'd2);
        tick();
        check("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        offer(2'd0, 16'h0303, 16'h0, 2'd0, 1'b1, 3'd3);
        tick(); tick();
        check("bp_still_full", {31'b0, in_ready}, 32'h0);
        check("bp_head_addr", {29'b0, rf_waddr}, 32'h1);
        rf_ready = 1'b1;
        tick();
        check("bp_second_head", {16'b0, rf_wdata}, 32'h0202);
        tick();
        idle();
        check("bp_third_head", {16'b0, rf_wdata}, 32'h0303);
        tick();
        check("bp_cnt", {16'b0, retire_cnt}, 32'h3);
        check("bp_ans", {16'b0, ans_wb}, 32'h0303);

        // register 0 and no-write retire without rf_ready
        rf_ready = 1'b0;
        offer(2'd0, 16'h5555, 16'h0, 2'd0, 1'b1, 3'd0);
        tick();
        idle();
        check("r0_rf_we", {31'b0, rf_we}, 32'h0);
        tick();
        check("r0_cnt", {16'b0, retire_cnt}, 32'h4);
        check("r0_ans", {16'b0, ans_wb}, 32'h0303);
        offer(2'd3, 16'h6666, 16'h0, 2'd0, 1'b1, 3'd6);
        tick();
        idle();
        check("none_rf_we", {31'b0, rf_we}, 32'h0);
        tick();
        check("none_cnt", {16'b0, retire_cnt}, 32'h5);

        // forwarding with head r3=0x0011, skid r3=0x0022
        offer(2'd0, 16'h0011, 16'h0, 2'd0, 1'b1, 3'd3);
        tick();
        offer(2'd0, 16'h0022, 16'h0, 2'd0, 1'b1, 3'd3);
        tick();
        idle();
        fwd_raddr = {3'd4, 3'd3};
        #1;
        check("fwd_hit_skid", {30'b0, fwd_hit}, 32'h1);
        check("fwd_data_p0", {16'b0, fwd_data[15:0]}, 32'h0022);
        check("fwd_data_p1", {16'b0, fwd_data[31:16]}, 32'h0);
        fwd_raddr = {3'd3, 3'd0};
        #1;
        check("fwd_hit_r0", {30'b0, fwd_hit}, 32'h2);

        // asynchronous reset while holding two entries
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'b0, in_ready}, 32'h1);
        check("arst_rf_we", {31'b0, rf_we}, 32'h0);
        check("arst_ans", {16'b0, ans_wb}, 32'h0);
        check("arst_cnt", {16'b0, retire_cnt}, 32'h0);
        check("arst_fwd_hit", {30'b0, fwd_hit}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        rf_ready = 1'b1;
        tick(); tick(); tick();
        check("post_reset_cnt", {16'b0, retire_cnt}, 32'h0);

        // mixed stream with intermittent stalls and bubbles
        k = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            logic [7:0] kb;
            kb = 8'(k);
            rf_ready  = ((cyc % 3) != 1);
            fwd_raddr = {3'(cyc % 8), 3'((cyc + 3) % 8)};
            if (k < 24 && (cyc % 5) != 4) begin
                offer(2'(k % 4), 16'h1000 + 16'(k) * 16'h0101,
                      {kb ^ 8'h5A, kb + 8'h80}, 2'((k / 4) % 4),
                      ((k % 7) != 6), 3'((k * 5) % 8));
            end else begin
                idle();
            end
            rdy = in_ready;
            tick();
            if (in_valid && rdy) k++;
        end
        idle();
        rf_ready = 1'b1;
        tick(); tick(); tick();
        check("stream_all_sent", 32'(k), 32'd24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
